// File: rtl/serial_capture_deser_if.sv
// Handshake/bus bundle between the serial capture deserializer and its environment.
// The deserializer uses the slave modport; the sender/consumer side uses master.
interface serial_capture_deser_if #(
   parameter int WIDTH  = 17,
   parameter int SLOT_W = 5
);
   logic              START;
   logic              EN;
   logic              SIN;
   logic              RDY;
   logic [WIDTH-1:0]  DOUT;
   logic              VALID;
   logic              BUSY;
   logic [SLOT_W-1:0] SLOT;
   logic              OVR;
   logic              PERR;

   modport slave (
      input  START, EN, SIN, RDY,
      output DOUT, VALID, BUSY, SLOT, OVR, PERR
   );

   modport master (
      output START, EN, SIN, RDY,
      input  DOUT, VALID, BUSY, SLOT, OVR, PERR
   );
endinterface

// File: rtl/serial_capture_deser.sv
// Slot-counter serial capture: samples SIN once per enabled slot, presents the word with VALID/RDY hold.
// Optional macro SERIAL_CAPTURE_PARITY_EN adds a trailing even-parity slot and drives PERR.
module serial_capture_deser #(
   parameter int WIDTH  = 17,
   parameter int SLOT_W = 5
) (
   input logic                  CK,
   input logic                  RST,
   serial_capture_deser_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      HOLD = 2'd2
   } state_t;

`ifdef SERIAL_CAPTURE_PARITY_EN
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIDTH);
`else
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIDTH - 1);
`endif

   state_t              state_r;
   logic [WIDTH-1:0]    shadow_r;
   logic [WIDTH-1:0]    dout_r;
   logic                valid_r;
   logic                busy_r;
   logic [SLOT_W-1:0]   slot_r;
   logic                ovr_r;
`ifdef SERIAL_CAPTURE_PARITY_EN
   logic                perr_r;
`endif

   // Capture FSM: slot counter, shadow assembly, hold handshake and overrun flag.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_r  <= IDLE;
         shadow_r <= '0;
         dout_r   <= '0;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         slot_r   <= '0;
         ovr_r    <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
         perr_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.START) begin
                  state_r  <= CAPT;
                  slot_r   <= '0;
                  shadow_r <= '0;
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            CAPT: begin
               if (bus.EN) begin
                  if (slot_r == LAST_SLOT) begin
                     dout_r  <= shadow_r;
`ifdef SERIAL_CAPTURE_PARITY_EN
                     perr_r  <= (^shadow_r) ^ bus.SIN;
`else
                     // Last data bit comes straight from the line, not the shadow.
                     dout_r[WIDTH-1] <= bus.SIN;
`endif
                     valid_r <= 1'b1;
                     busy_r  <= 1'b0;
                     slot_r  <= '0;
                     state_r <= HOLD;
                  end else begin
                     shadow_r[slot_r] <= bus.SIN;
                     slot_r           <= slot_r + SLOT_W'(1);
                  end
               end else begin
                  state_r <= CAPT;
               end
            end
            HOLD: begin
               if (bus.RDY) begin
                  valid_r <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
                  perr_r  <= 1'b0;
`endif
                  if (bus.START) begin
                     state_r  <= CAPT;
                     slot_r   <= '0;
                     shadow_r <= '0;
                     busy_r   <= 1'b1;
                  end else begin
                     state_r  <= IDLE;
                  end
               end else if (bus.START) begin
                  // Request arrives while the consumer still owns the word: drop it, remember it.
                  ovr_r <= 1'b1;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               slot_r  <= '0;
            end
         endcase
      end
   end

   assign bus.DOUT  = dout_r;
   assign bus.VALID = valid_r;
   assign bus.BUSY  = busy_r;
   assign bus.SLOT  = slot_r;
   assign bus.OVR   = ovr_r;
`ifdef SERIAL_CAPTURE_PARITY_EN
   assign bus.PERR  = perr_r;
`else
   assign bus.PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_capture_deser.sv
// Table-driven bench for serial_capture_deser with an expected-word scoreboard queue.
module tb_serial_capture_deser;

   localparam int W  = 17;
   localparam int SW = 5;
`ifdef SERIAL_CAPTURE_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NSLOT = W + (PAR ? 1 : 0);

   typedef struct {
      logic [W-1:0] word;
      int           s0;
      int           s1;
      int           slen;
      logic         parbit;
      int           hold;
   } vec_t;

   typedef struct {
      logic [W-1:0] dout;
      logic         perr;
   } exp_t;

   logic CK;
   logic RST;
   int   checks;
   int   errors;
   exp_t sbq[$];
   vec_t vecs[6];

   serial_capture_deser_if #(.WIDTH(W), .SLOT_W(SW)) bus ();

   serial_capture_deser #(.WIDTH(W), .SLOT_W(SW)) dut (
      .CK  (CK),
      .RST (RST),
      .bus (bus)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic tick;
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic capture(input logic [W-1:0] word, input int s0, input int s1, input int slen,
                          input logic parbit, input int hold, input bit do_start, input bit rel);
      exp_t e;
      exp_t got;
      int   cyc;
      int   stalls;
      int   n;
      e.dout = word;
      e.perr = PAR ? ((^word) ^ parbit) : 1'b0;
      sbq.push_back(e);
      if (do_start) begin
         bus.START = 1'b1;
         tick();
         bus.START = 1'b0;
         chk("start_busy", 32'(bus.BUSY), 32'd1);
         chk("start_slot", 32'(bus.SLOT), 32'd0);
      end
      cyc = 0;
      stalls = 0;
      for (int i = 0; i < NSLOT; i++) begin
         bus.EN  = 1'b1;
         bus.SIN = (i < W) ? word[i] : parbit;
         tick();
         cyc++;
         if (i < NSLOT - 1 && (i == s0 || i == s1)) begin
            for (int k = 0; k < slen; k++) begin
               bus.EN    = 1'b0;
               bus.SIN   = 1'($urandom);
               bus.START = (k == 0);
               bus.RDY   = (k == 1);
               tick();
               cyc++;
               stalls++;
               bus.START = 1'b0;
               bus.RDY   = 1'b0;
               chk("stall_slot_frozen", 32'(bus.SLOT), 32'(i + 1));
            end
         end
      end
      bus.EN  = 1'b0;
      bus.SIN = 1'b0;
      n = 0;
      while (!bus.VALID && n < 4) begin
         tick();
         n++;
      end
      chk("valid_rise", 32'(bus.VALID), 32'd1);
      chk("latency", 32'(cyc + n), 32'(NSLOT + stalls));
      if (sbq.size() > 0) begin
         got = sbq.pop_front();
         chk("dout", 32'(bus.DOUT), 32'(got.dout));
         chk("perr", 32'(bus.PERR), 32'(got.perr));
      end else begin
         chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
      end
      chk("done_busy_slot", 32'({bus.BUSY, bus.SLOT}), 32'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_valid", 32'(bus.VALID), 32'd1);
         chk("hold_dout", 32'(bus.DOUT), 32'(e.dout));
      end
      if (rel) begin
         bus.RDY = 1'b1;
         tick();
         bus.RDY = 1'b0;
         chk("release", 32'({bus.VALID, bus.BUSY, bus.PERR}), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{17'h1A5A5, -1, -1, 0, 1'b1, 5};
      vecs[1] = '{17'h1A5A5,  4, 11, 3, 1'b1, 0};
      vecs[2] = '{17'h00007, -1, -1, 0, 1'b1, 0};
      vecs[3] = '{17'h00007, -1, -1, 0, 1'b0, 0};
      vecs[4] = '{17'h0FFFF,  0, 15, 2, 1'b0, 1};
      vecs[5] = '{17'h00000,  7, -1, 1, 1'b1, 0};
      checks = 0;
      errors = 0;
      RST = 1'b1;
      bus.START = 1'b0;
      bus.EN    = 1'b0;
      bus.SIN   = 1'b0;
      bus.RDY   = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("reset_idle", 32'({bus.DOUT, bus.VALID, bus.BUSY, bus.SLOT, bus.OVR, bus.PERR}), 32'd0);
      end

      for (int v = 0; v < 6; v++) begin
         capture(vecs[v].word, vecs[v].s0, vecs[v].s1, vecs[v].slen,
                 vecs[v].parbit, vecs[v].hold, 1'b1, 1'b1);
      end
      chk("no_ovr_in_capt", 32'(bus.OVR), 32'd0);

      // Overrun: START while holding, then RDY+START chains straight into a new capture.
      capture(17'h1A5A5, -1, -1, 0, 1'b1, 1, 1'b1, 1'b0);
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      chk("ovr_set", 32'(bus.OVR), 32'd1);
      chk("ovr_valid_held", 32'(bus.VALID), 32'd1);
      chk("ovr_dout_held", 32'(bus.DOUT), 32'h1A5A5);
      tick();
      chk("ovr_sticky", 32'({bus.OVR, bus.VALID}), 32'd3);
      bus.START = 1'b1;
      bus.RDY   = 1'b1;
      tick();
      bus.START = 1'b0;
      bus.RDY   = 1'b0;
      chk("chain_valid", 32'(bus.VALID), 32'd0);
      chk("chain_busy", 32'(bus.BUSY), 32'd1);
      chk("chain_slot", 32'(bus.SLOT), 32'd0);
      capture(17'h00001, -1, -1, 0, 1'b1, 0, 1'b0, 1'b1);
      chk("ovr_still_set", 32'(bus.OVR), 32'd1);

      // Reset in the middle of a capture.
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.EN  = 1'b1;
         bus.SIN = 1'b1;
         tick();
      end
      chk("pre_reset_slot", 32'(bus.SLOT), 32'd9);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.EN = 1'b0;
      chk("mid_reset", 32'({bus.DOUT, bus.VALID, bus.BUSY, bus.SLOT, bus.OVR, bus.PERR}), 32'd0);
      tick();
      chk("post_reset_idle", 32'({bus.VALID, bus.BUSY, bus.SLOT}), 32'd0);
      capture(17'h10000, -1, -1, 0, 1'b1, 0, 1'b1, 1'b1);

      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
